// File: rtl/virtual_button_conditioner_pkg.sv
// Shared constants, event payload and priority-encode helper for the virtual button path.
package virtual_button_conditioner_pkg;

  localparam int unsigned VIO_NUM_BUTTONS = 24;
  localparam int unsigned VIO_IDX_W       = 5;
  localparam int unsigned VIO_NUM_LEDS    = 8;

  // One cycle's press summary before it is registered
  typedef struct packed {
    logic                 valid;
    logic [VIO_IDX_W-1:0] index;
  } press_evt_t;

  // Index of the lowest set bit; 0 when nothing is set
  function automatic logic [VIO_IDX_W-1:0] lowest_set(input logic [31:0] v);
    logic [VIO_IDX_W-1:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = VIO_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/virtual_button_channel.sv
// One button: retriggerable hold stretcher plus toggle flop.
module virtual_button_channel
  import virtual_button_conditioner_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 200,
  parameter int unsigned HOLD_W     = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic strobe,
  input  logic tick,
  output logic held,
  output logic toggle
);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;

  // Reload on strobe (wins over tick), otherwise count down once per tick
  always_comb begin
    hold_nxt = r_hold_cnt;
    if (strobe) begin
      hold_nxt = HOLD_W'(HOLD_TICKS);
    end else if (tick && (r_hold_cnt != '0)) begin
      hold_nxt = r_hold_cnt - HOLD_W'(1);
    end
  end

  // Hold counter, registered held level and toggle state
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hold_cnt <= '0;
      held       <= 1'b0;
      toggle     <= 1'b0;
    end else begin
      r_hold_cnt <= hold_nxt;
      held       <= (hold_nxt != '0);
      toggle     <= toggle ^ strobe;
    end
  end

endmodule

// File: rtl/virtual_button_conditioner.sv
// Conditions UART virtual button strobes into held levels, toggles and a press event stream.
module virtual_button_conditioner
  import virtual_button_conditioner_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS = VIO_NUM_BUTTONS,
  parameter int unsigned TICK_CLKS   = 100000,
  parameter int unsigned HOLD_TICKS  = 200,
  parameter int unsigned HOLD_W      = 8,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_BUTTONS-1:0]  buttons,
  output logic [NUM_BUTTONS-1:0]  buttons_held,
  output logic [NUM_BUTTONS-1:0]  buttons_toggle,
  output logic                    press_event,
  output logic [VIO_IDX_W-1:0]    press_index,
  output logic [COUNT_W-1:0]      press_count,
  output logic [VIO_NUM_LEDS-1:0] led_status
);

  localparam int unsigned TICK_W = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;

  logic [TICK_W-1:0] r_tick_cnt;
  logic              tick_c;
  press_evt_t        evt_c;

  assign tick_c = (r_tick_cnt == TICK_W'(TICK_CLKS - 1));

  // Free-running hold-tick prescaler
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tick_cnt <= '0;
    end else if (tick_c) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  // Per-button hold and toggle channels
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    virtual_button_channel #(
      .HOLD_TICKS (HOLD_TICKS),
      .HOLD_W     (HOLD_W)
    ) u_chan (
      .CLK    (CLK),
      .RST    (RST),
      .strobe (buttons[i]),
      .tick   (tick_c),
      .held   (buttons_held[i]),
      .toggle (buttons_toggle[i])
    );
  end

  // Summarise this cycle's strobes: any-set flag and lowest index
  always_comb begin
    evt_c       = '0;
    evt_c.valid = |buttons;
    evt_c.index = lowest_set(32'(buttons));
  end

  // Registered press event, sticky index and saturating press counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      press_event <= 1'b0;
      press_index <= '0;
      press_count <= '0;
    end else begin
      press_event <= evt_c.valid;
      if (evt_c.valid) begin
        press_index <= evt_c.index;
        if (press_count != '1) press_count <= press_count + COUNT_W'(1);
      end
    end
  end

  assign led_status = VIO_NUM_LEDS'(buttons_toggle);

endmodule
